// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// 16 lines x 4 words x 32 bits, 16-bit byte address (tag[15:8], index[7:4], word[3:2]).
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata - memory-stage request (held while cpu_stall)
//   cpu_rdata, cpu_stall      - load data (0 unless a load completes) and stall
//   mem_rden/mem_rdaddress/mem_read_data - refill read port (combinational data)
//   mem_wren/mem_wraddress/mem_write_data - registered write-through port
module dcache_wt (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_rden,
    output logic [15:0] mem_rdaddress,
    input  logic [31:0] mem_read_data,
    output logic        mem_wren,
    output logic [15:0] mem_wraddress,
    output logic [31:0] mem_write_data
);
    localparam int unsigned LINES  = 16;
    localparam int unsigned WORDS  = 4;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned WORD_W = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WADR_W = TAG_W + IDX_W + WORD_W;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t state, next_state;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_ram  [LINES];
    logic [DATA_W-1:0] data_ram [LINES*WORDS];

    // Request address fields
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_word;
    logic              req_hit;
    logic [1:0]        unused_addr_bits;

    assign req_tag          = cpu_addr[15:8];
    assign req_idx          = cpu_addr[7:4];
    assign req_word         = cpu_addr[3:2];
    assign req_hit          = valid[req_idx] && (tag_ram[req_idx] == req_tag);
    assign unused_addr_bits = cpu_addr[1:0];

    // Refill line base and beat counter
    logic [TAG_W-1:0]  rf_tag;
    logic [IDX_W-1:0]  rf_idx;
    logic [WORD_W-1:0] beat;

    // Latched store (word address and data) and registered write enable
    logic [WADR_W-1:0] wr_waddr;
    logic [DATA_W-1:0] wr_data;
    logic              wren_q;
    logic              wr_hit;

    assign wr_hit = valid[wr_waddr[5:2]] && (tag_ram[wr_waddr[5:2]] == wr_waddr[13:6]);

    // State register
    always_ff @(posedge clk) begin
        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        if (rst) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        if (cpu_we)        next_state = WRITE;
                        else if (!req_hit) next_state = REFILL;
                    end
                end
                REFILL:  if (beat == 2'd3) next_state = IDLE;
                WRITE:   next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Output logic; reset masks every strobe and the load data
    always_comb begin
        cpu_stall     = 1'b0;
        cpu_rdata     = '0;
        mem_rden      = 1'b0;
        mem_rdaddress = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (cpu_req && (cpu_we || !req_hit)) cpu_stall = 1'b1;
                    if (cpu_req && !cpu_we && req_hit)
                        cpu_rdata = data_ram[{req_idx, req_word}];
                end
                REFILL: begin
                    cpu_stall     = 1'b1;
                    mem_rden      = 1'b1;
                    mem_rdaddress = {rf_tag, rf_idx, beat, 2'b00};
                end
                default: ;
            endcase
        end
    end

    assign mem_wren       = wren_q & ~rst;
    assign mem_wraddress  = {wr_waddr, 2'b00};
    assign mem_write_data = wr_data;

    // Control registers: valid bits, tags, refill/store latches
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= '0;
            beat   <= '0;
            wren_q <= 1'b0;
        end else begin
            wren_q <= (next_state == WRITE);
            if (state == IDLE && cpu_req) begin
                if (cpu_we) begin
                    wr_waddr <= cpu_addr[15:2];
                    wr_data  <= cpu_wdata;
                end else if (!req_hit) begin
                    rf_tag <= req_tag;
                    rf_idx <= req_idx;
                    beat   <= '0;
                end
            end
            if (state == REFILL) begin
                beat <= beat + 2'd1;
                // Invalidate first so a half-filled line never hits
                if (beat == 2'd0) valid[rf_idx] <= 1'b0;
                if (beat == 2'd3) begin
                    valid[rf_idx]   <= 1'b1;
                    tag_ram[rf_idx] <= rf_tag;
                end
            end
        end
    end

    // Data array: refill beats and write-through hit updates
    always_ff @(posedge clk) begin
        if (!rst && state == REFILL)
            data_ram[{rf_idx, beat}] <= mem_read_data;
        else if (!rst && state == WRITE && wr_hit)
            data_ram[wr_waddr[5:0]] <= wr_data;
    end

endmodule
